// File: rtl/match_pkg.sv
// Shared definitions for the match logger: parameter defaults, the
// enable state encoding and the default timestamp type.
package match_pkg;

    localparam int TS_W_DEF  = 16;
    localparam int DEPTH_DEF = 4;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    typedef logic [TS_W_DEF-1:0] ts_t;

endpackage

// File: rtl/match_fifo.sv
// Synchronous FIFO holding logged timestamps. A push into a full FIFO is
// accepted only when a pop happens in the same cycle. The head data reads
// as zero while the FIFO is empty.
module match_fifo
    import match_pkg::*;
#(
    parameter int W     = TS_W_DEF,
    parameter int DEPTH = DEPTH_DEF,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic [W-1:0]  data_i,
    input  logic          pop_i,
    output logic [W-1:0]  data_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   level_o
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          pop_ok;
    logic          push_ok;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign level_o = count_q;
    assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    assign pop_ok  = pop_i & ~empty_o;
    assign push_ok = push_i & (~full_o | pop_ok);

    // Pointer and occupancy next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers; reset empties the FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write; contents are don't-care while not counted as occupied.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/match_logger.sv
// Match logger: timestamps single-cycle match pulses while enabled and
// queues them for a valid/ready consumer. Lost events set a sticky
// overflow flag. Defining MATCH_LOGGER_DROP_CNT_EN adds an 8-bit
// saturating drop counter on drop_cnt_o.
//
// The enable state follows en_i as sampled on each edge, and the edge that
// samples en_i already behaves according to the new state (counts and logs).
module match_logger
    import match_pkg::*;
#(
    parameter int TS_W  = TS_W_DEF,
    parameter int DEPTH = DEPTH_DEF,
    localparam int LW   = $clog2(DEPTH) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en_i,
    input  logic            match_i,
    input  logic            clr_i,
    output logic            evt_valid_o,
    input  logic            evt_ready_i,
    output logic [TS_W-1:0] evt_ts_o,
    output logic [LW-1:0]   level_o,
`ifdef MATCH_LOGGER_DROP_CNT_EN
    output logic [7:0]      drop_cnt_o,
`endif
    output logic            ovf_o
);

    state_e          state_q, state_d;
    logic [TS_W-1:0] ts_q, ts_d;
    logic            ovf_q, ovf_d;
    logic            run;
    logic            push_req;
    logic            pop;
    logic            drop;
    logic            fifo_full;
    logic            fifo_empty;

    // Enable state transition.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (en_i)  state_d = RUN;
            RUN:     if (!en_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign run      = (state_d == RUN);
    assign pop      = evt_valid_o & evt_ready_i;
    assign push_req = match_i & run;
    assign drop     = push_req & fifo_full & ~pop;

    // Timestamp counter and sticky overflow next-state; a drop beats a clear.
    always_comb begin
        ts_d  = run ? ts_q + TS_W'(1) : ts_q;
        ovf_d = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (clr_i) begin
            ovf_d = 1'b0;
        end
    end

    // State, timestamp and overflow registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ts_q    <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ts_q    <= ts_d;
            ovf_q   <= ovf_d;
        end
    end

    assign ovf_o       = ovf_q;
    assign evt_valid_o = ~fifo_empty;

    match_fifo #(
        .W     (TS_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_req),
        .data_i  (ts_q),
        .pop_i   (pop),
        .data_o  (evt_ts_o),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (level_o)
    );

`ifdef MATCH_LOGGER_DROP_CNT_EN
    logic [7:0] drop_cnt_q, drop_cnt_d;

    // Drop counter next-state: clear restarts at the current drop, else saturate.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (clr_i) begin
            drop_cnt_d = drop ? 8'd1 : 8'd0;
        end else if (drop && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    // Drop counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt_o = drop_cnt_q;
`endif

endmodule

// File: tb/tb_match_logger.sv
// Directed bench for match_logger with a timestamp scoreboard and a small
// reference model of level, overflow and drop count.
module tb_match_logger;

    localparam int TS_W  = 16;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic            clk = 1'b0;
    logic            rst;
    logic            en_i;
    logic            match_i;
    logic            clr_i;
    logic            evt_valid_o;
    logic            evt_ready_i;
    logic [TS_W-1:0] evt_ts_o;
    logic [LW-1:0]   level_o;
    logic            ovf_o;
`ifdef MATCH_LOGGER_DROP_CNT_EN
    logic [7:0]      drop_cnt_o;
`endif

    int checks = 0;
    int errors = 0;

    logic [TS_W-1:0] sb[$];
    logic [TS_W-1:0] m_ts;
    logic            m_ovf;
    logic [7:0]      m_cnt;
    logic [TS_W-1:0] frozen_ts;

    always #5 clk = ~clk;

    match_logger #(
        .TS_W  (TS_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en_i        (en_i),
        .match_i     (match_i),
        .clr_i       (clr_i),
        .evt_valid_o (evt_valid_o),
        .evt_ready_i (evt_ready_i),
        .evt_ts_o    (evt_ts_o),
        .level_o     (level_o),
`ifdef MATCH_LOGGER_DROP_CNT_EN
        .drop_cnt_o  (drop_cnt_o),
`endif
        .ovf_o       (ovf_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: check current outputs against the model, apply the
    // inputs to the model, clock, then check the registered status flags.
    task automatic cyc(input logic en, input logic mt, input logic rd, input logic cl);
        logic            pop;
        logic            push;
        logic            drop;
        logic [TS_W-1:0] head;
        en_i        = en;
        match_i     = mt;
        evt_ready_i = rd;
        clr_i       = cl;
        chk("level", 32'(level_o), 32'(sb.size()));
        chk("valid", 32'(evt_valid_o), 32'(sb.size() != 0));
        if (sb.size() != 0) begin
            chk("head_ts", 32'(evt_ts_o), 32'(sb[0]));
        end
        pop = (sb.size() != 0) && rd;
        if (pop) begin
            head = sb.pop_front();
        end
        push = mt && en;
        drop = push && (sb.size() == DEPTH);
        if (push && !drop) begin
            sb.push_back(m_ts);
        end
        if (drop) begin
            m_ovf = 1'b1;
        end else if (cl) begin
            m_ovf = 1'b0;
        end
        if (cl) begin
            m_cnt = drop ? 8'd1 : 8'd0;
        end else if (drop && (m_cnt != 8'hFF)) begin
            m_cnt = m_cnt + 8'd1;
        end
        if (en) begin
            m_ts = m_ts + 16'd1;
        end
        @(posedge clk);
        #1;
        chk("ovf", 32'(ovf_o), 32'(m_ovf));
`ifdef MATCH_LOGGER_DROP_CNT_EN
        chk("drop_cnt", 32'(drop_cnt_o), 32'(m_cnt));
`endif
    endtask

    // Reset with every other input active to show reset priority.
    task automatic do_reset();
        rst         = 1'b1;
        en_i        = 1'b1;
        match_i     = 1'b1;
        evt_ready_i = 1'b1;
        clr_i       = 1'b0;
        @(posedge clk);
        #1;
        rst     = 1'b0;
        en_i    = 1'b0;
        match_i = 1'b0;
        sb.delete();
        m_ts  = '0;
        m_ovf = 1'b0;
        m_cnt = '0;
        chk("rst_level", 32'(level_o), 32'd0);
        chk("rst_valid", 32'(evt_valid_o), 32'd0);
        chk("rst_ts", 32'(evt_ts_o), 32'd0);
        chk("rst_ovf", 32'(ovf_o), 32'd0);
`ifdef MATCH_LOGGER_DROP_CNT_EN
        chk("rst_drop_cnt", 32'(drop_cnt_o), 32'd0);
`endif
    endtask

    initial begin
        rst         = 1'b1;
        en_i        = 1'b0;
        match_i     = 1'b0;
        clr_i       = 1'b0;
        evt_ready_i = 1'b0;
        m_ts        = '0;
        m_ovf       = 1'b0;
        m_cnt       = '0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // First event at ts=5, visible next cycle, then drained.
        repeat (5) cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        chk("first_valid", 32'(evt_valid_o), 32'd1);
        chk("first_ts", 32'(evt_ts_o), 32'd5);
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        chk("first_drained", 32'(level_o), 32'd0);

        // Five matches at odd timestamps into a depth-4 FIFO.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, m_ts[0], 1'b0, 1'b0);
        end
        chk("ovf_level", 32'(level_o), 32'd4);
        chk("ovf_flag", 32'(ovf_o), 32'd1);
`ifdef MATCH_LOGGER_DROP_CNT_EN
        chk("ovf_drop_cnt", 32'(drop_cnt_o), 32'd1);
`endif
        chk("drain0", 32'(evt_ts_o), 32'd1);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk("drain1", 32'(evt_ts_o), 32'd3);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk("drain2", 32'(evt_ts_o), 32'd5);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk("drain3", 32'(evt_ts_o), 32'd7);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("clr_ovf", 32'(ovf_o), 32'd0);

        // Full FIFO with push and pop together: no drop, level stays 4.
        repeat (4) cyc(1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        chk("full_pp_level", 32'(level_o), 32'd4);
        chk("full_pp_ovf", 32'(ovf_o), 32'd0);

        // Drop coinciding with clear: overflow wins.
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        chk("clr_drop_ovf", 32'(ovf_o), 32'd1);
`ifdef MATCH_LOGGER_DROP_CNT_EN
        chk("clr_drop_cnt", 32'(drop_cnt_o), 32'd1);
`endif
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        repeat (3) cyc(1'b0, 1'b0, 1'b1, 1'b0);

        // Push and pop on a partially filled FIFO keep the level.
        repeat (2) cyc(1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        chk("mid_pp_level", 32'(level_o), 32'd2);
        repeat (2) cyc(1'b0, 1'b0, 1'b1, 1'b0);

        // Disabled: matches ignored, ts frozen, queued events still drain.
        repeat (2) cyc(1'b1, 1'b1, 1'b0, 1'b0);
        frozen_ts = m_ts;
        repeat (4) cyc(1'b0, 1'b1, 1'b0, 1'b0);
        chk("idle_level", 32'(level_o), 32'd2);
        repeat (2) cyc(1'b0, 1'b1, 1'b1, 1'b0);
        chk("idle_drained", 32'(level_o), 32'd0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        chk("frozen_ts", 32'(evt_ts_o), 32'(frozen_ts));
        cyc(1'b0, 1'b0, 1'b1, 1'b0);

        // Timestamp wrap from all-ones to zero.
        while (m_ts != 16'hFFFF) begin
            cyc(1'b1, 1'b0, 1'b1, 1'b0);
        end
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        chk("wrap_ts0", 32'(evt_ts_o), 32'h0000FFFF);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk("wrap_ts1", 32'(evt_ts_o), 32'h00000000);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);

        // Reset with three queued events and overflow set.
        repeat (5) cyc(1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk("pre_rst_level", 32'(level_o), 32'd3);
        chk("pre_rst_ovf", 32'(ovf_o), 32'd1);
        do_reset();
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        chk("post_rst_ts", 32'(evt_ts_o), 32'd0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk("final_level", 32'(level_o), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
